// File: rtl/stepper_step_ctrl.sv
// -----------------------------------------------------------------------------
// stepper_step_ctrl
// Drives a 4-phase stepper through 45-degree segments until the position error
// supplied by the upstream angle-position FSM reaches zero. Owns the registered
// physical shaft position that feeds back to that FSM; because it is registered
// here the feedback path has no combinational loop.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   enable       in   permits starting new segments
//   pos_error    in   desired minus physical position, modulo 2**POS_WIDTH
//   physical_pos out  registered current shaft position
//   coil         out  one-hot coil drive (always energised)
//   step_pulse   out  one-cycle pulse per motor step
//   dir          out  1 = CW, 0 = CCW, latched per segment
//   busy         out  high while a segment is in progress
//   at_target    out  IDLE and pos_error == 0 (combinational)
// -----------------------------------------------------------------------------
module stepper_step_ctrl #(
  parameter int POS_WIDTH     = 3,
  parameter int STEPS_PER_POS = 8,
  parameter int STEP_DIV      = 1000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [POS_WIDTH-1:0] pos_error,
  output logic [POS_WIDTH-1:0] physical_pos,
  output logic [3:0]           coil,
  output logic                 step_pulse,
  output logic                 dir,
  output logic                 busy,
  output logic                 at_target
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] DIV_LAST  = CNT_WIDTH'(STEP_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] STEP_LAST = CNT_WIDTH'(STEPS_PER_POS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [POS_WIDTH-1:0] POS_ZERO  = {POS_WIDTH{1'b0}};
  localparam logic [POS_WIDTH-1:0] POS_ONE   = {{(POS_WIDTH-1){1'b0}}, 1'b1};
  // Half a revolution; an error of exactly half a turn is resolved as CW.
  localparam logic [POS_WIDTH-1:0] POS_HALF  = {1'b1, {(POS_WIDTH-1){1'b0}}};

  // Phase index to one-hot coil pattern.
  function automatic logic [3:0] coil_of(input logic [1:0] ph);
    logic [3:0] c;
    case (ph)
      2'd0:    c = 4'b0001;
      2'd1:    c = 4'b0010;
      2'd2:    c = 4'b0100;
      2'd3:    c = 4'b1000;
      default: c = 4'b0001;
    endcase
    return c;
  endfunction

  state_e                 state_q, state_d;
  logic [POS_WIDTH-1:0]   pos_q, pos_d;
  logic [1:0]             phase_q, phase_d;
  logic [3:0]             coil_q, coil_d;
  logic                   pulse_q, pulse_d;
  logic                   dir_q, dir_d;
  logic                   busy_q, busy_d;
  logic [CNT_WIDTH-1:0]   step_cnt_q, step_cnt_d;
  logic [CNT_WIDTH-1:0]   div_cnt_q, div_cnt_d;

  logic start_ok_s;
  logic err_cw_s;
  logic div_last_s;
  logic seg_last_s;

  assign start_ok_s = enable && (pos_error != POS_ZERO);
  assign err_cw_s   = (pos_error != POS_ZERO) && (pos_error <= POS_HALF);
  assign div_last_s = (div_cnt_q == DIV_LAST);
  assign seg_last_s = div_last_s && (step_cnt_q == CNT_ZERO);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pos_q      <= POS_ZERO;
      phase_q    <= 2'd0;
      coil_q     <= 4'b0001;
      pulse_q    <= 1'b0;
      dir_q      <= 1'b0;
      busy_q     <= 1'b0;
      step_cnt_q <= CNT_ZERO;
      div_cnt_q  <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      phase_q    <= phase_d;
      coil_q     <= coil_d;
      pulse_q    <= pulse_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      step_cnt_q <= step_cnt_d;
      div_cnt_q  <= div_cnt_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) state_d = ST_RUN;
        else            state_d = ST_IDLE;
      end
      ST_RUN: begin
        // A segment always runs to completion; enable and error are ignored here.
        if (seg_last_s) state_d = ST_CHECK;
        else            state_d = ST_RUN;
      end
      ST_CHECK: begin
        if (start_ok_s) state_d = ST_RUN;
        else            state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    pos_d      = pos_q;
    phase_d    = phase_q;
    dir_d      = dir_q;
    step_cnt_d = step_cnt_q;
    div_cnt_d  = div_cnt_q;
    pulse_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_CHECK: begin
        if (start_ok_s) begin
          dir_d      = err_cw_s;
          step_cnt_d = STEP_LAST;
          div_cnt_d  = CNT_ZERO;
        end else begin
          dir_d      = dir_q;
        end
      end
      ST_RUN: begin
        if (div_last_s) begin
          div_cnt_d = CNT_ZERO;
          pulse_d   = 1'b1;
          if (dir_q) phase_d = phase_q + 2'd1;
          else       phase_d = phase_q - 2'd1;
          // Final motor step of the segment also moves the shaft one position.
          if (step_cnt_q == CNT_ZERO) begin
            if (dir_q) pos_d = pos_q + POS_ONE;
            else       pos_d = pos_q - POS_ONE;
          end else begin
            step_cnt_d = step_cnt_q - CNT_ONE;
          end
        end else begin
          div_cnt_d = div_cnt_q + CNT_ONE;
        end
      end
      default: begin
        pos_d = pos_q;
      end
    endcase
    coil_d = coil_of(phase_d);
    busy_d = (state_d != ST_IDLE);
  end

  assign physical_pos = pos_q;
  assign coil         = coil_q;
  assign step_pulse   = pulse_q;
  assign dir          = dir_q;
  assign busy         = busy_q;
  assign at_target    = (state_q == ST_IDLE) && (pos_error == POS_ZERO);

endmodule

// File: tb/tb_stepper_step_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for stepper_step_ctrl with STEP_DIV=4, STEPS_PER_POS=2.
// The upstream position FSM is modelled as target - physical_pos (mod 8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_stepper_step_ctrl;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] target;
  logic [2:0] pos_error;
  logic [2:0] physical_pos;
  logic [3:0] coil;
  logic       step_pulse;
  logic       dir;
  logic       busy;
  logic       at_target;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int c;
  int idle_c;

  assign pos_error = target - physical_pos;

  stepper_step_ctrl #(
    .POS_WIDTH    (3),
    .STEPS_PER_POS(2),
    .STEP_DIV     (4),
    .CNT_WIDTH    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pos_error   (pos_error),
    .physical_pos(physical_pos),
    .coil        (coil),
    .step_pulse  (step_pulse),
    .dir         (dir),
    .busy        (busy),
    .at_target   (at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Count falling edges until step_pulse is seen; max_c+1 means it never came.
  task automatic wait_pulse(input int max_c, output int cyc, output int idle_cyc);
    cyc = max_c + 1;
    idle_cyc = 0;
    for (int i = 1; i <= max_c; i++) begin
      @(negedge clk);
      if (!busy) idle_cyc++;
      if (step_pulse) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    target = 3'd0;

    // 1. Reset and idle
    repeat (3) @(negedge clk);
    check_eq("rst_coil_in_reset", 32'(coil), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_coil", 32'(coil), 32'h1);
    check_eq("rst_pos", 32'(physical_pos), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_pulse", 32'(step_pulse), 32'd0);
    check_eq("rst_at_target", 32'(at_target), 32'd1);
    enable = 1'b1;
    wait_pulse(10, c, idle_c);
    check_eq("idle_no_pulse", 32'(c), 32'd11);
    // enable low in IDLE with a nonzero error: no motion
    enable = 1'b0;
    target = 3'd3;
    wait_pulse(10, c, idle_c);
    check_eq("dis_no_pulse", 32'(c), 32'd11);
    check_eq("dis_busy", 32'(busy), 32'd0);
    check_eq("dis_at_target", 32'(at_target), 32'd0);

    // 3. CCW from position 0, wrapping to 7
    target = 3'd7;
    enable = 1'b1;
    wait_pulse(20, c, idle_c);
    check_eq("ccw_p1_lat", 32'(c), 32'd5);
    check_eq("ccw_dir", 32'(dir), 32'd0);
    check_eq("ccw_p1_coil", 32'(coil), 32'h8);
    check_eq("ccw_p1_pos", 32'(physical_pos), 32'd0);
    wait_pulse(20, c, idle_c);
    check_eq("ccw_p2_lat", 32'(c), 32'd4);
    check_eq("ccw_p2_coil", 32'(coil), 32'h4);
    check_eq("ccw_p2_pos", 32'(physical_pos), 32'd7);
    @(negedge clk);
    check_eq("ccw_end_busy", 32'(busy), 32'd0);
    check_eq("ccw_end_at", 32'(at_target), 32'd1);

    // 2. CW single segment (7 -> 0)
    target = 3'd0;
    wait_pulse(20, c, idle_c);
    check_eq("cw_p1_lat", 32'(c), 32'd5);
    check_eq("cw_dir", 32'(dir), 32'd1);
    check_eq("cw_busy", 32'(busy), 32'd1);
    check_eq("cw_p1_coil", 32'(coil), 32'h8);
    check_eq("cw_p1_pos", 32'(physical_pos), 32'd7);
    wait_pulse(20, c, idle_c);
    check_eq("cw_p2_lat", 32'(c), 32'd4);
    check_eq("cw_p2_coil", 32'(coil), 32'h1);
    check_eq("cw_p2_pos", 32'(physical_pos), 32'd0);
    check_eq("cw_check_at", 32'(at_target), 32'd0);
    @(negedge clk);
    check_eq("cw_end_busy", 32'(busy), 32'd0);
    check_eq("cw_end_at", 32'(at_target), 32'd1);
    check_eq("cw_end_pulse", 32'(step_pulse), 32'd0);

    // 4. Error of 4 resolves CW; four back-to-back segments
    target = 3'd4;
    for (int seg = 1; seg <= 4; seg++) begin
      wait_pulse(20, c, idle_c);
      check_eq("tie_first_lat", 32'(c), 32'd5);
      check_eq("tie_busy_a", 32'(idle_c), 32'd0);
      check_eq("tie_dir", 32'(dir), 32'd1);
      wait_pulse(20, c, idle_c);
      check_eq("tie_second_lat", 32'(c), 32'd4);
      check_eq("tie_busy_b", 32'(idle_c), 32'd0);
      check_eq("tie_pos", 32'(physical_pos), 32'(seg));
    end
    check_eq("tie_coil", 32'(coil), 32'h1);
    @(negedge clk);
    check_eq("tie_end_busy", 32'(busy), 32'd0);
    check_eq("tie_end_at", 32'(at_target), 32'd1);

    // 5. enable dropped mid-segment: segment completes, then IDLE
    target = 3'd7;
    wait_pulse(20, c, idle_c);
    check_eq("drop_p1_lat", 32'(c), 32'd5);
    @(negedge clk);
    enable = 1'b0;
    wait_pulse(20, c, idle_c);
    check_eq("drop_p2_lat", 32'(c), 32'd3);
    check_eq("drop_pos", 32'(physical_pos), 32'd5);
    check_eq("drop_coil", 32'(coil), 32'h4);
    @(negedge clk);
    check_eq("drop_busy", 32'(busy), 32'd0);
    check_eq("drop_at", 32'(at_target), 32'd0);
    wait_pulse(12, c, idle_c);
    check_eq("drop_no_more", 32'(c), 32'd13);
    check_eq("drop_pos_hold", 32'(physical_pos), 32'd5);

    // 6. Reset asserted two cycles into RUN
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("mid_busy", 32'(busy), 32'd1);
    reset  = 1'b0;
    target = 3'd0;
    #1;
    check_eq("mrst_pos", 32'(physical_pos), 32'd0);
    check_eq("mrst_coil", 32'(coil), 32'h1);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_dir", 32'(dir), 32'd0);
    check_eq("mrst_pulse", 32'(step_pulse), 32'd0);
    check_eq("mrst_at", 32'(at_target), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    wait_pulse(12, c, idle_c);
    check_eq("mrst_no_pulse", 32'(c), 32'd13);
    check_eq("mrst_busy_after", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
